// File: rtl/reorder_buffer_pkg.sv
// ---------------------------------------------------------------------------
// reorder_buffer_pkg
// Shared ROB definitions reused by the register file, dispatcher and
// reservation stations: tag width, the reserved "no dependency" tag, the
// ROB entry layout and the tag <-> index conversions (tag = index + 1).
// ---------------------------------------------------------------------------
package reorder_buffer_pkg;

  localparam int TAG_W = 5;
  localparam logic [TAG_W-1:0] NO_TAG = '0;

  typedef struct packed {
    logic             busy;
    logic             ready;
    logic [4:0]       rd;
    logic             is_branch;
    logic             mispredict;
    logic [31:0]      value;
    logic [31:0]      target_pc;
  } rob_entry_t;

  function automatic logic [TAG_W-1:0] tag_to_idx(input logic [TAG_W-1:0] tag);
    return tag - TAG_W'(1);
  endfunction

  function automatic logic [TAG_W-1:0] idx_to_tag(input logic [TAG_W-1:0] idx);
    return idx + TAG_W'(1);
  endfunction

endpackage

// File: rtl/reorder_buffer_rob_ptr_ctrl.sv
// ---------------------------------------------------------------------------
// reorder_buffer_rob_ptr_ctrl
// Head/tail/count bookkeeping for the circular reorder buffer. Pointers wrap
// naturally modulo DEPTH (power of two). A flush returns everything to zero
// and takes priority over any push/pop on the same edge.
//   i_clk, i_rst   : clock, asynchronous active-high reset
//   i_push, i_pop  : one entry allocated / retired this edge (already gated)
//   i_flush        : mispredict retire, empty the buffer
//   o_head, o_tail : current head / tail indices
//   o_full         : count == DEPTH
// ---------------------------------------------------------------------------
module reorder_buffer_rob_ptr_ctrl #(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [IDX_W-1:0] o_head,
  output logic [IDX_W-1:0] o_tail,
  output logic             o_full
);

  logic [IDX_W-1:0] r_head;
  logic [IDX_W-1:0] r_tail;
  logic [IDX_W:0]   r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_pop)  r_head <= r_head + 1'b1;
      if (i_push) r_tail <= r_tail + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head = r_head;
  assign o_tail = r_tail;
  assign o_full = (r_count == (IDX_W+1)'(DEPTH));

endmodule

// File: rtl/reorder_buffer.sv
// ---------------------------------------------------------------------------
// reorder_buffer
// Circular reorder buffer: allocates rename tags (index + 1) in program
// order, captures CDB write-backs, retires at most one entry per cycle in
// order and drives the commit / rollback interface. Two combinational
// operand query ports serve the dispatcher.
// Optional feature: define ROB_CDB_BYPASS_EN to let queries see a
// same-cycle CDB result for a busy entry.
//   clk_in, rst_in, rdy_in          : clock, async active-high reset, enable
//   alloc_*                         : dispatcher allocation request / next tag / full
//   wb_*                            : CDB result broadcast
//   query_tag*/ready*/value*        : operand lookups (tag 0 = none)
//   commit_*                        : registered retire pulse and fields
//   rollback_flag / rollback_pc     : registered flush pulse and redirect PC
// ---------------------------------------------------------------------------
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             alloc_en,
  input  logic [4:0]       alloc_rd,
  input  logic             alloc_is_branch,
  output logic [TAG_W-1:0] alloc_tag,
  output logic             full,
  input  logic             wb_en,
  input  logic [TAG_W-1:0] wb_tag,
  input  logic [31:0]      wb_value,
  input  logic             wb_mispredict,
  input  logic [31:0]      wb_target_pc,
  input  logic [TAG_W-1:0] query_tag1,
  input  logic [TAG_W-1:0] query_tag2,
  output logic             query_ready1,
  output logic             query_ready2,
  output logic [31:0]      query_value1,
  output logic [31:0]      query_value2,
  output logic             commit_flag,
  output logic [4:0]       commit_rd,
  output logic [TAG_W-1:0] commit_tag,
  output logic [31:0]      commit_value,
  output logic             rollback_flag,
  output logic [31:0]      rollback_pc
);

  rob_entry_t       r_ent [DEPTH];
  logic             r_commit_flag;
  logic [4:0]       r_commit_rd;
  logic [TAG_W-1:0] r_commit_tag;
  logic [31:0]      r_commit_value;
  logic             r_rollback_flag;
  logic [31:0]      r_rollback_pc;

  logic [IDX_W-1:0] w_head;
  logic [IDX_W-1:0] w_tail;
  logic             w_full;
  rob_entry_t       w_head_ent;
  logic             w_pop;
  logic             w_flush;
  logic             w_push;
  logic [IDX_W-1:0] w_wb_idx;
  logic             w_wb_hit;
  logic [TAG_W-1:0] w_q_tag   [2];
  logic [IDX_W-1:0] w_q_idx   [2];
  logic             w_q_ready [2];
  logic [31:0]      w_q_value [2];

  assign w_head_ent = r_ent[w_head];
  assign w_pop      = rdy_in & w_head_ent.busy & w_head_ent.ready;
  assign w_flush    = w_pop & w_head_ent.is_branch & w_head_ent.mispredict;
  // r_rollback_flag doubles as rollback_pending: no allocation in the flush cycle
  assign w_push     = rdy_in & alloc_en & ~w_full & ~r_rollback_flag;

  assign w_wb_idx = IDX_W'(tag_to_idx(wb_tag));
  assign w_wb_hit = rdy_in & wb_en & (wb_tag != NO_TAG) & (wb_tag <= TAG_W'(DEPTH))
                    & r_ent[w_wb_idx].busy;

  reorder_buffer_rob_ptr_ctrl #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ptr (
    .i_clk   (clk_in),
    .i_rst   (rst_in),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .o_head  (w_head),
    .o_tail  (w_tail),
    .o_full  (w_full)
  );

  // Order matters: write-back, then retire clears busy, then allocation,
  // then a flush wipes every busy bit (discarding a same-edge allocation).
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_ent[i] <= '0;
      r_commit_flag   <= 1'b0;
      r_commit_rd     <= '0;
      r_commit_tag    <= '0;
      r_commit_value  <= '0;
      r_rollback_flag <= 1'b0;
      r_rollback_pc   <= '0;
    end else if (!rdy_in) begin
      // pulses must not reappear when the enable returns
      r_commit_flag   <= 1'b0;
      r_rollback_flag <= 1'b0;
    end else begin
      r_commit_flag   <= w_pop;
      r_rollback_flag <= w_flush;
      if (w_pop) begin
        r_commit_rd    <= w_head_ent.rd;
        r_commit_tag   <= idx_to_tag(TAG_W'(w_head));
        r_commit_value <= w_head_ent.value;
      end
      if (w_flush) r_rollback_pc <= w_head_ent.target_pc;
      if (w_wb_hit) begin
        r_ent[w_wb_idx].ready      <= 1'b1;
        r_ent[w_wb_idx].value      <= wb_value;
        r_ent[w_wb_idx].mispredict <= wb_mispredict;
        r_ent[w_wb_idx].target_pc  <= wb_target_pc;
      end
      if (w_pop) r_ent[w_head].busy <= 1'b0;
      if (w_push) begin
        r_ent[w_tail] <= '{busy: 1'b1, ready: 1'b0, rd: alloc_rd,
                           is_branch: alloc_is_branch, mispredict: 1'b0,
                           value: '0, target_pc: '0};
      end
      if (w_flush) begin
        for (int unsigned i = 0; i < DEPTH; i++) r_ent[i].busy <= 1'b0;
      end
    end
  end

  assign w_q_tag[0] = query_tag1;
  assign w_q_tag[1] = query_tag2;
  assign w_q_idx[0] = IDX_W'(tag_to_idx(query_tag1));
  assign w_q_idx[1] = IDX_W'(tag_to_idx(query_tag2));

  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      w_q_ready[p] = 1'b0;
      w_q_value[p] = '0;
      if ((w_q_tag[p] != NO_TAG) && (w_q_tag[p] <= TAG_W'(DEPTH))) begin
        if (r_ent[w_q_idx[p]].busy && r_ent[w_q_idx[p]].ready) begin
          w_q_ready[p] = 1'b1;
          w_q_value[p] = r_ent[w_q_idx[p]].value;
        end
`ifdef ROB_CDB_BYPASS_EN
        if (wb_en && (w_q_tag[p] == wb_tag) && r_ent[w_q_idx[p]].busy) begin
          w_q_ready[p] = 1'b1;
          w_q_value[p] = wb_value;
        end
`endif
      end
    end
  end

  assign query_ready1  = w_q_ready[0];
  assign query_value1  = w_q_value[0];
  assign query_ready2  = w_q_ready[1];
  assign query_value2  = w_q_value[1];

  assign alloc_tag     = idx_to_tag(TAG_W'(w_tail));
  assign full          = w_full;
  assign commit_flag   = r_commit_flag & rdy_in;
  assign commit_rd     = r_commit_rd;
  assign commit_tag    = r_commit_tag;
  assign commit_value  = r_commit_value;
  assign rollback_flag = r_rollback_flag & rdy_in;
  assign rollback_pc   = r_rollback_pc;

endmodule
